// File: rtl/adc_spi_intf.sv
// SPI master for a 12-bit ADC: one conversion is a channel-select transaction
// followed by an identical transaction that returns the result.
module adc_spi_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX1  = 2'd1,
        GAP  = 2'd2,
        TX2  = 2'd3
    } state_t;

    localparam logic [4:0] DIV_IDLE   = 5'b10111;
    localparam logic [4:0] DIV_SAMPLE = 5'b10001;
    localparam logic [4:0] DIV_SHIFT  = 5'b11111;
    // The start edge already counts as the first divider tick, giving an
    // 8-clk front porch before the first SCLK fall.
    localparam logic [4:0] DIV_START  = DIV_IDLE + 5'd1;
    localparam logic [4:0] LAST_SHIFT = 5'd15;
    localparam logic [4:0] ALL_SHIFTS = 5'd16;

    state_t      state, state_nxt;
    logic        ss_n_q, ss_n_nxt;
    logic [4:0]  div_q, div_nxt;
    logic [15:0] shft_q, shft_nxt;
    logic        smpl_q, smpl_nxt;
    logic        smpl_taken_q, smpl_taken_nxt;
    logic [4:0]  bit_cnt_q, bit_cnt_nxt;
    logic [2:0]  chnl_q, chnl_nxt;
    logic        gap_cnt_q, gap_cnt_nxt;
    logic        cmplt_q, cmplt_nxt;
    logic [11:0] res_q, res_nxt;

    assign SS_n      = ss_n_q;
    assign SCLK      = div_q[4];
    assign MOSI      = shft_q[15];
    assign cnv_cmplt = cmplt_q;
    assign res       = res_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ss_n_q       <= 1'b1;
            div_q        <= DIV_IDLE;
            shft_q       <= 16'h0000;
            smpl_q       <= 1'b0;
            smpl_taken_q <= 1'b0;
            bit_cnt_q    <= 5'd0;
            chnl_q       <= 3'd0;
            gap_cnt_q    <= 1'b0;
            cmplt_q      <= 1'b0;
            res_q        <= 12'h000;
        end else begin
            state        <= state_nxt;
            ss_n_q       <= ss_n_nxt;
            div_q        <= div_nxt;
            shft_q       <= shft_nxt;
            smpl_q       <= smpl_nxt;
            smpl_taken_q <= smpl_taken_nxt;
            bit_cnt_q    <= bit_cnt_nxt;
            chnl_q       <= chnl_nxt;
            gap_cnt_q    <= gap_cnt_nxt;
            cmplt_q      <= cmplt_nxt;
            res_q        <= res_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first; a path
        // that leaves one unassigned would otherwise infer a latch.
        state_nxt      = state;
        ss_n_nxt       = ss_n_q;
        div_nxt        = div_q;
        shft_nxt       = shft_q;
        smpl_nxt       = smpl_q;
        smpl_taken_nxt = smpl_taken_q;
        bit_cnt_nxt    = bit_cnt_q;
        chnl_nxt       = chnl_q;
        gap_cnt_nxt    = gap_cnt_q;
        cmplt_nxt      = cmplt_q;
        res_nxt        = res_q;

        unique case (state)
            IDLE: begin
                if (strt_cnv) begin
                    chnl_nxt       = chnnl;
                    shft_nxt       = {2'b00, chnnl, 11'h000};
                    ss_n_nxt       = 1'b0;
                    div_nxt        = DIV_START;
                    bit_cnt_nxt    = 5'd0;
                    smpl_taken_nxt = 1'b0;
                    cmplt_nxt      = 1'b0;
                    state_nxt      = TX1;
                end
            end

            TX1, TX2: begin
                if (bit_cnt_q == ALL_SHIFTS) begin
                    ss_n_nxt = 1'b1;
                    div_nxt  = DIV_IDLE;
                    if (state == TX1) begin
                        gap_cnt_nxt = 1'b0;
                        state_nxt   = GAP;
                    end else begin
                        res_nxt   = shft_q[11:0];
                        cmplt_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    div_nxt = div_q + 5'd1;
                    if (div_q == DIV_SAMPLE) begin
                        smpl_nxt       = MISO;
                        smpl_taken_nxt = 1'b1;
                    end
                    // The front-porch pass through DIV_SHIFT has no sample yet.
                    if (div_q == DIV_SHIFT && smpl_taken_q) begin
                        shft_nxt    = {shft_q[14:0], smpl_q};
                        bit_cnt_nxt = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LAST_SHIFT)
                            div_nxt = DIV_IDLE;  // park SCLK high, no 17th fall
                    end
                end
            end

            GAP: begin
                if (!gap_cnt_q) begin
                    gap_cnt_nxt = 1'b1;
                end else begin
                    shft_nxt       = {2'b00, chnl_q, 11'h000};
                    ss_n_nxt       = 1'b0;
                    div_nxt        = DIV_START;
                    bit_cnt_nxt    = 5'd0;
                    smpl_taken_nxt = 1'b0;
                    state_nxt      = TX2;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc_spi_intf.sv
// Randomized bench for adc_spi_intf: an ADC slave model answers on SPI while a
// scoreboard checks commands, results, completion timing and SPI waveform.
module tb_adc_spi_intf;

    logic        clk;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    adc_spi_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected conversion: command word, ADC replies for both transactions,
    // and the cycle at which cnv_cmplt must rise.
    typedef struct {
        logic [15:0] cmd;
        logic [15:0] w1;
        logic [15:0] w2;
        int          done_cyc;
    } conv_t;

    conv_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    sclk_edges = 0;
    bit    b2b_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(SCLK) sclk_edges++;

    // ADC slave model: shifts its reply out on SCLK falls, captures MOSI on rises.
    int          adc_bit;
    logic [15:0] adc_cmd;
    bit          adc_tx2 = 1'b0;

    always @(negedge rst_n) adc_tx2 = 1'b0;

    always @(negedge SS_n) if (rst_n) begin
        adc_bit = 15;
        adc_cmd = 16'h0000;
    end

    always @(negedge SCLK) if (rst_n && !SS_n && adc_bit >= 0) begin
        logic [15:0] w;
        w = 16'h0000;
        if (exp_q.size() > 0) w = adc_tx2 ? exp_q[0].w2 : exp_q[0].w1;
        MISO = w[adc_bit];
        adc_bit--;
    end

    always @(posedge SCLK) if (rst_n && !SS_n) adc_cmd = {adc_cmd[14:0], MOSI};

    always @(posedge SS_n) if (rst_n) begin
        if (exp_q.size() > 0)
            check(adc_tx2 ? "tx2_cmd" : "tx1_cmd", {16'h0, adc_cmd}, {16'h0, exp_q[0].cmd});
        adc_tx2 = ~adc_tx2;
    end

    // Monitor: SPI timing and the completion scoreboard, sampled on falling clk.
    bit prev_ss = 1'b1, prev_sclk = 1'b1, prev_cmplt = 1'b0;
    bit first_fall_seen, mon_tx2;
    int t_ss_fall, t_ss_rise, rises, last_rise, t_cmplt_rise;

    always @(negedge clk) begin
        if (!rst_n) begin
            rises           = 0;
            first_fall_seen = 1'b0;
            mon_tx2         = 1'b0;
        end else begin
            if (prev_ss && !SS_n) begin
                if (mon_tx2) check("gap_len", t_ss_fall >= 0 ? cyc - t_ss_rise : 0, 2);
                t_ss_fall       = cyc;
                rises           = 0;
                first_fall_seen = 1'b0;
            end
            if (!SS_n && prev_sclk && !SCLK && !first_fall_seen) begin
                first_fall_seen = 1'b1;
                check("front_porch", cyc - t_ss_fall, 8);
            end
            if (!SS_n && !prev_sclk && SCLK) begin
                if (rises > 0) check("sclk_period", cyc - last_rise, 32);
                rises++;
                last_rise = cyc;
            end
            if (!prev_ss && SS_n) begin
                check("sclk_rises", rises, 16);
                check("sclk_high_at_ss_rise", SCLK, 1);
                check("ss_low_len", cyc - t_ss_fall, 521);
                t_ss_rise = cyc;
                mon_tx2   = ~mon_tx2;
            end
            if (!prev_cmplt && cnv_cmplt) begin
                t_cmplt_rise = cyc;
                if (exp_q.size() == 0) begin
                    check("spurious_cnv_cmplt", 1, 0);
                end else begin
                    conv_t e;
                    e = exp_q.pop_front();
                    check("res", res, e.w2[11:0]);
                    check("done_cycle", cyc, e.done_cyc);
                end
            end
            if (prev_cmplt && !cnv_cmplt && b2b_mode)
                check("cmplt_pulse_len", cyc - t_cmplt_rise, 1);
        end
        prev_ss    = SS_n;
        prev_sclk  = SCLK;
        prev_cmplt = cnv_cmplt;
    end

    // Issue one strt_cnv pulse at the next clk edge and queue its expectation.
    task automatic start_conv(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2);
        conv_t e;
        @(negedge clk);
        chnnl    = ch;
        strt_cnv = 1'b1;
        e.cmd = {2'b00, ch, 11'h000};
        e.w1  = w1;
        e.w2  = w2;
        e.done_cyc = cyc + 1 + 1044;
        exp_q.push_back(e);
        @(negedge clk);
        strt_cnv = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [11:0] held;
        logic [2:0]  ch;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        MISO     = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("rst_SS_n", SS_n, 1);
        check("rst_SCLK", SCLK, 1);
        check("rst_MOSI", MOSI, 0);
        check("rst_cnv_cmplt", cnv_cmplt, 0);
        check("rst_res", res, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed single conversion, then result/flag hold.
        start_conv(3'b101, 16'($urandom), {4'($urandom), 12'hABC});
        wait_done();
        repeat (20) @(negedge clk);
        check("cmplt_held", cnv_cmplt, 1);
        check("res_held", res, 12'hABC);

        // strt_cnv with another channel in the middle of a conversion is ignored.
        start_conv(3'b001, 16'($urandom), 16'($urandom));
        repeat (299) @(negedge clk);
        chnnl    = 3'b111;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        wait_done();

        // Data extremes with the upper nibble set.
        start_conv(3'($urandom), 16'($urandom), 16'hF000);
        wait_done();
        start_conv(3'($urandom), 16'($urandom), 16'hFFFF);
        wait_done();

        // Random conversions.
        for (int i = 0; i < 3; i++) begin
            start_conv(3'($urandom), 16'($urandom), 16'($urandom));
            wait_done();
            repeat ($urandom_range(1, 10)) @(negedge clk);
        end

        // Back-to-back: strt_cnv held high for three conversions.
        @(negedge clk);
        ch       = 3'($urandom);
        chnnl    = ch;
        strt_cnv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            conv_t e;
            e.cmd = {2'b00, ch, 11'h000};
            e.w1  = 16'($urandom);
            e.w2  = 16'($urandom);
            e.done_cyc = cyc + 1 + 1044 + i * 1045;
            exp_q.push_back(e);
        end
        repeat (2) @(negedge clk);
        b2b_mode = 1'b1;
        repeat (3133) @(negedge clk);
        strt_cnv = 1'b0;
        wait_done();
        b2b_mode = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_no_restart", SS_n, 1);

        // Reset in the middle of TX1 aborts the conversion.
        held = res;
        start_conv(3'($urandom), 16'($urandom), 16'($urandom));
        repeat (200) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_SS_n", SS_n, 1);
        check("abort_SCLK", SCLK, 1);
        check("abort_cnv_cmplt", cnv_cmplt, 0);
        check("abort_res", res, 12'h000);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            int e0;
            e0 = sclk_edges;
            repeat (100) @(negedge clk);
            check("idle_sclk_edges", sclk_edges - e0, 0);
        end
        check("res_not_restored", (res == held && held != 12'h000) ? 1 : 0, 0);

        // A full conversion after the abort.
        start_conv(3'($urandom), 16'($urandom), 16'($urandom));
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_intf.md
ADC_SPI_INTF -- requirements
Module: adc_spi_intf

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all flops on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port strt_cnv, input, 1: request one conversion of channel chnnl.
REQ-004 SHALL have port chnnl, input, 3: ADC channel to convert; sampled only on strt_cnv accept.
REQ-005 SHALL have port cnv_cmplt, output, 1: conversion done; level, held until the next accepted strt_cnv.
REQ-006 SHALL have port res, output, 12: last conversion result; held between conversions.
REQ-007 SHALL have port SS_n, output, 1: ADC slave select, active low, registered.
REQ-008 SHALL have port SCLK, output, 1: SPI clock, idle high, registered.
REQ-009 SHALL have port MOSI, output, 1: command data to the ADC.
REQ-010 SHALL have port MISO, input, 1: result data from the ADC.

Function
REQ-011 SHALL implement FSM states IDLE, TX1, GAP, TX2; one conversion SHALL be two 16-bit SPI transactions (TX1 selects the channel, TX2 returns the result).
REQ-012 IDLE + strt_cnv=1 SHALL, on that edge: load the 16-bit shift register with {2'b00, chnnl, 11'h000}, drive SS_n low, clear cnv_cmplt, enter TX1.
REQ-013 strt_cnv SHALL be ignored outside IDLE; chnnl SHALL be captured once per conversion.
REQ-014 A 5-bit divider SHALL be loaded with 5'b10111 at each transaction start, increment every clk while SS_n is low, and hold 5'b10111 otherwise; SCLK SHALL equal divider bit 4.
REQ-015 MOSI SHALL equal shift-register bit 15 at all times, MSB first.
REQ-016 MISO SHALL be captured into a 1-bit sample flop on each clk where divider==5'b10001, i.e. 2 clk after each SCLK rise.
REQ-017 On divider==5'b11111 with at least one sample taken in the current transaction, the register SHALL shift left and take the sample flop as LSB.
REQ-018 The first divider==5'b11111 of a transaction (front porch, no sample yet) SHALL NOT shift.
REQ-019 After the 16th shift, the divider SHALL stop and SCLK SHALL remain high (no 17th fall).
REQ-020 On the next edge after the 16th shift, SS_n SHALL go high.
REQ-021 Each transaction SHALL hold SS_n low exactly 521 clk: 8-clk front porch, 16 SCLK periods of 32 clk, shift on the last clk.
REQ-022 TX1 end SHALL enter GAP, which holds SS_n high exactly 2 clk.
REQ-023 On leaving GAP, the block SHALL reload the same command word, drive SS_n low, and enter TX2.
REQ-024 TX2 end SHALL, on the same edge SS_n rises: set res to shift register [11:0] (bits [15:12] discarded), set cnv_cmplt=1, and return to IDLE.
REQ-025 Latency: with strt_cnv accepted at edge 0, SS_n SHALL be low over edges 0-520 and 523-1043, and cnv_cmplt/res SHALL update at edge 1044.
REQ-026 strt_cnv in the same cycle that cnv_cmplt sets SHALL be ignored, since the FSM is still in TX2; strt_cnv on any later IDLE cycle SHALL be accepted.

Reset
REQ-027 rst_n low SHALL force, asynchronously: state IDLE, SS_n=1, SCLK=1 (divider 5'b10111), shift register 0 (MOSI=0), sample flop 0, cnv_cmplt=0, res=12'h000.
REQ-028 Reset asserted mid-transaction SHALL abort it with no update to res; after release, the first strt_cnv SHALL start a full conversion.

Verification
REQ-029 Reset check: assert rst_n=0 mid-TX1 -> immediately SS_n=1, SCLK=1, cnv_cmplt=0, res=000; no SCLK edges until the next strt_cnv.
REQ-030 Single conversion: ADC model returns 12'hABC for chnnl=3'b101, strt_cnv pulse at edge 0 -> model sees 16'h2800 on MOSI in both transactions; res=12'hABC and cnv_cmplt=1 at edge 1044.
REQ-031 SPI timing: count 16 SCLK rises per transaction, 32-clk period, 8 clk SS_n fall to first SCLK fall, SCLK high at SS_n rise, SS_n high exactly 2 clk between TX1 and TX2.
REQ-032 Ignore-busy: pulse strt_cnv with chnnl=3'b111 at edge 300 of a chnnl=3'b001 conversion -> no restart, TX2 command still 16'h0800, single cnv_cmplt at edge 1044.
REQ-033 Back-to-back: strt_cnv held high continuously -> cnv_cmplt high for 1 clk per conversion, new SS_n fall on edge after cnv_cmplt rises, res updated every 1045 clk.
REQ-034 Data extremes: model returns 12'h000, then 12'hFFF with MISO bits [15:12]=4'hF -> res=000, then FFF; upper nibble never appears on res.
